// File: rtl/arquitetura_nios2_qsys_0_jtag_cmd_issue_queue.sv
// arquitetura_nios2_qsys_0_jtag_cmd_issue_queue: synchronised JTAG update capture into a FIFO, issued as one-hot action pulses
module arquitetura_nios2_qsys_0_jtag_cmd_issue_queue #(
  parameter int IR_W        = 2,
  parameter int SR_W        = 38,
  parameter int ACT_BIT     = 35,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            vs_udr,
  input  logic                            vs_uir,
  input  logic [IR_W-1:0]                 ir_in,
  input  logic [SR_W-1:0]                 sr,
  input  logic                            hold,
  input  logic                            clr_overflow,
  output logic [SR_W-1:0]                 jdo,
  output logic [2**IR_W-1:0]              take_action,
  output logic [2**IR_W-1:0]              take_no_action,
  output logic                            uir_pulse,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            overflow
);
  localparam int NCH = 2**IR_W;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int CW  = $clog2(SYNC_STAGES + 2);
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] udr_s, uir_s;
  logic udr_p, uir_p, armed, udr_e, uir_e, push, pop, full, empty;
  logic [CW-1:0] arm;
  logic [IR_W+SR_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [IR_W-1:0] head_ir;
  logic [SR_W-1:0] head_sr;
  always_comb begin
    armed = arm == CW'(SYNC_STAGES + 1);
    udr_e = armed & udr_s[SYNC_STAGES-1] & ~udr_p;
    uir_e = armed & uir_s[SYNC_STAGES-1] & ~uir_p;
    full = fifo_level == LW'(FIFO_DEPTH);
    empty = fifo_level == '0;
    pop = state == ISSUE && !empty && !hold;
    push = udr_e && (!full || pop);
    state_nx = (!empty && !hold) ? ISSUE : IDLE;
    {head_ir, head_sr} = mem[rp];
  end
  always_ff @(posedge clk)
    if (push) mem[wp] <= {ir_in, sr};
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      udr_s <= '0;
      uir_s <= '0;
      udr_p <= 1'b0;
      uir_p <= 1'b0;
      arm <= '0;
      state <= IDLE;
      wp <= '0;
      rp <= '0;
      fifo_level <= '0;
      overflow <= 1'b0;
      uir_pulse <= 1'b0;
      jdo <= '0;
      take_action <= '0;
      take_no_action <= '0;
    end else begin
      udr_s <= {udr_s[SYNC_STAGES-2:0], vs_udr};
      uir_s <= {uir_s[SYNC_STAGES-2:0], vs_uir};
      udr_p <= udr_s[SYNC_STAGES-1];
      uir_p <= uir_s[SYNC_STAGES-1];
      arm <= armed ? arm : arm + 1'b1;
      state <= state_nx;
      wp <= push ? wp + 1'b1 : wp;
      rp <= pop ? rp + 1'b1 : rp;
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
      // a new drop wins over a same-cycle clear
      overflow <= (udr_e & full & ~pop) | (overflow & ~clr_overflow);
      uir_pulse <= uir_e;
      jdo <= pop ? head_sr : jdo;
      take_action <= (pop && head_sr[ACT_BIT]) ? NCH'(1) << head_ir : '0;
      take_no_action <= (pop && !head_sr[ACT_BIT]) ? NCH'(1) << head_ir : '0;
    end
  end
endmodule

// File: tb/tb_arquitetura_nios2_qsys_0_jtag_cmd_issue_queue.sv
// tb_arquitetura_nios2_qsys_0_jtag_cmd_issue_queue: directed table and sequence checks of the JTAG command issue queue
module tb_arquitetura_nios2_qsys_0_jtag_cmd_issue_queue;
  logic clk = 0, reset_n = 0, vs_udr = 0, vs_uir = 0, hold = 0, clr_overflow = 0;
  logic [1:0] ir_in = 0;
  logic [37:0] sr = 0, jdo;
  logic [3:0] take_action, take_no_action;
  logic uir_pulse, overflow;
  logic [2:0] fifo_level;
  int total = 0, errors = 0;
  typedef struct {logic [1:0] ir; logic [37:0] sr; logic [3:0] ta; logic [3:0] tna;} vec_t;
  vec_t vecs[5];
  arquitetura_nios2_qsys_0_jtag_cmd_issue_queue dut (
    .clk(clk), .reset_n(reset_n), .vs_udr(vs_udr), .vs_uir(vs_uir), .ir_in(ir_in), .sr(sr),
    .hold(hold), .clr_overflow(clr_overflow), .jdo(jdo), .take_action(take_action),
    .take_no_action(take_no_action), .uir_pulse(uir_pulse), .fifo_level(fifo_level), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic capture(input logic [1:0] ir, input logic [37:0] d);
    ir_in = ir;
    sr = d;
    vs_udr = 1;
    repeat (4) tick();
    vs_udr = 0;
    repeat (4) tick();
  endtask
  function automatic logic [37:0] mk(input int i);
    logic [31:0] v = 32'hA5A5_0000 + 32'(i);
    return {2'b00, i[0], 3'b000, v};
  endfunction
  initial begin
    int stray, n, first, last;
    logic bad;
    vecs[0] = '{2'b01, 38'h08_0000_0001, 4'b0010, 4'b0000};
    vecs[1] = '{2'b10, 38'h00_1234_5678, 4'b0000, 4'b0100};
    vecs[2] = '{2'b00, 38'h3F_FFFF_FFFF, 4'b0001, 4'b0000};
    vecs[3] = '{2'b11, 38'h37_FFFF_FFFF, 4'b0000, 4'b1000};
    vecs[4] = '{2'b11, 38'h08_0000_0000, 4'b1000, 4'b0000};
    vs_udr = 1;
    repeat (3) tick();
    chk("reset_jdo", 64'(jdo), 0);
    chk("reset_pulses", 64'({take_action, take_no_action, uir_pulse}), 0);
    chk("reset_level", 64'(fifo_level), 0);
    chk("reset_ovf", 64'(overflow), 0);
    reset_n = 1;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (fifo_level != 0 || take_action != 0 || take_no_action != 0) bad = 1;
    end
    chk("held_udr_no_capture", 64'(bad), 0);
    vs_udr = 0;
    repeat (4) tick();
    for (int v = 0; v < 5; v++) begin
      ir_in = vecs[v].ir;
      sr = vecs[v].sr;
      vs_udr = 1;
      stray = 0;
      for (int k = 1; k <= 7; k++) begin
        tick();
        if (k == 4) vs_udr = 0;
        if (k == 5) begin
          chk($sformatf("vec%0d_ta", v), 64'(take_action), 64'(vecs[v].ta));
          chk($sformatf("vec%0d_tna", v), 64'(take_no_action), 64'(vecs[v].tna));
          chk($sformatf("vec%0d_jdo", v), 64'(jdo), 64'(vecs[v].sr));
        end else if (take_action != 0 || take_no_action != 0) stray++;
      end
      chk($sformatf("vec%0d_stray", v), 64'(stray), 0);
      chk($sformatf("vec%0d_jdo_hold", v), 64'(jdo), 64'(vecs[v].sr));
      chk($sformatf("vec%0d_level", v), 64'(fifo_level), 0);
      repeat (3) tick();
    end
    hold = 1;
    for (int i = 0; i < 5; i++) capture(2'(i), mk(i));
    chk("full_level", 64'(fifo_level), 4);
    chk("full_overflow", 64'(overflow), 1);
    hold = 0;
    n = 0;
    first = -1;
    last = -1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (take_action != 0 || take_no_action != 0) begin
        if (n < 4) begin
          chk($sformatf("drain%0d_ta", n), 64'(take_action), n[0] ? 64'(4'b1 << n) : 0);
          chk($sformatf("drain%0d_tna", n), 64'(take_no_action), n[0] ? 0 : 64'(4'b1 << n));
          chk($sformatf("drain%0d_jdo", n), 64'(jdo), 64'(mk(n)));
        end
        if (first < 0) first = k;
        last = k;
        n++;
      end
    end
    chk("drain_count", 64'(n), 4);
    chk("drain_consecutive", 64'(last - first), 3);
    clr_overflow = 1;
    tick();
    clr_overflow = 0;
    chk("ovf_cleared", 64'(overflow), 0);
    hold = 1;
    for (int i = 0; i < 4; i++) capture(2'(i), mk(i));
    chk("refill_level", 64'(fifo_level), 4);
    vs_udr = 1;
    tick();
    hold = 0;
    tick();
    tick();
    hold = 1;
    chk("push_pop_full_level", 64'(fifo_level), 4);
    chk("push_pop_full_ovf", 64'(overflow), 0);
    vs_udr = 0;
    repeat (4) tick();
    chk("push_pop_full_settled", 64'(fifo_level), 4);
    vs_udr = 1;
    tick();
    tick();
    clr_overflow = 1;
    tick();
    clr_overflow = 0;
    chk("set_beats_clr", 64'(overflow), 1);
    vs_udr = 0;
    clr_overflow = 1;
    tick();
    clr_overflow = 0;
    chk("clr_alone", 64'(overflow), 0);
    hold = 0;
    repeat (8) tick();
    chk("drained_level", 64'(fifo_level), 0);
    hold = 1;
    for (int i = 0; i < 3; i++) capture(2'(i), mk(i));
    chk("three_level", 64'(fifo_level), 3);
    vs_uir = 1;
    n = 0;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == 4) vs_uir = 0;
      if (uir_pulse) n++;
      if (fifo_level != 3) bad = 1;
    end
    chk("uir_pulse_count", 64'(n), 1);
    chk("uir_level_unchanged", 64'(bad), 0);
    hold = 0;
    reset_n = 0;
    tick();
    chk("midreset_level", 64'(fifo_level), 0);
    chk("midreset_pulses", 64'({take_action, take_no_action}), 0);
    reset_n = 1;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (fifo_level != 0 || take_action != 0 || take_no_action != 0) bad = 1;
    end
    chk("post_reset_quiet", 64'(bad), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", total, errors);
    $finish;
  end
endmodule
